// File: rtl/mem_block_mover.sv
// Bus-initiator engine that fills or copies blocks of 32-bit words in the
// word-addressed test memory, driving the same bus the memory presents to the CPU.
module mem_block_mover #(
  parameter int READ_WAIT = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [15:31] src_addr,
  input  logic [15:31] dst_addr,
  input  logic [15:31] count,
  input  logic [0:31]  fill_value,
  output logic         busy,
  output logic         done,
  output logic [15:31] address,
  output logic         write_en,
  output logic [0:31]  data_out,
  input  logic [0:31]  data_in
);

  localparam int WAIT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

  typedef enum logic [2:0] {IDLE, FILL, READ, WRITE, DONE} state_t;

  state_t              state, state_n;
  logic [15:31]        src_q, src_n;
  logic [15:31]        dst_q, dst_n;
  logic [15:31]        remaining, remaining_n;
  logic [0:31]         fill_q, fill_n;
  logic [0:31]         hold, hold_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic                busy_n, done_n, write_en_n;
  logic [15:31]        address_n;
  logic [0:31]         data_out_n;

  // Bus outputs are registered: each transition loads what the next state drives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      remaining <= '0;
      fill_q    <= '0;
      hold      <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      write_en  <= 1'b0;
      address   <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      remaining <= remaining_n;
      fill_q    <= fill_n;
      hold      <= hold_n;
      wait_cnt  <= wait_n;
      busy      <= busy_n;
      done      <= done_n;
      write_en  <= write_en_n;
      address   <= address_n;
      data_out  <= data_out_n;
    end
  end

  always_comb begin
    state_n     = state;
    src_n       = src_q;
    dst_n       = dst_q;
    remaining_n = remaining;
    fill_n      = fill_q;
    hold_n      = hold;
    wait_n      = wait_cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    write_en_n  = 1'b0;
    address_n   = address;
    data_out_n  = data_out;
    case (state)
      IDLE: begin
        if (start) begin
          src_n       = src_addr;
          dst_n       = dst_addr;
          remaining_n = count;
          fill_n      = fill_value;
          wait_n      = '0;
          busy_n      = 1'b1;
          if (count == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (!mode) begin
            state_n    = FILL;
            address_n  = dst_addr;
            write_en_n = 1'b1;
            data_out_n = fill_value;
          end else begin
            state_n   = READ;
            address_n = src_addr;
          end
        end
      end
      FILL: begin
        dst_n       = dst_q + 17'd1;
        remaining_n = remaining - 17'd1;
        if (remaining == 17'd1) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          address_n  = dst_q + 17'd1;
          write_en_n = 1'b1;
          data_out_n = fill_q;
        end
      end
      READ: begin
        // data_in is combinational from address, so the last wait cycle samples it.
        if (wait_cnt == WAIT_LAST) begin
          hold_n     = data_in;
          wait_n     = '0;
          state_n    = WRITE;
          address_n  = dst_q;
          write_en_n = 1'b1;
          data_out_n = data_in;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      WRITE: begin
        src_n       = src_q + 17'd1;
        dst_n       = dst_q + 17'd1;
        remaining_n = remaining - 17'd1;
        data_out_n  = hold;
        if (remaining == 17'd1) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n   = READ;
          address_n = src_q + 17'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
